// File: rtl/pwm_pkg.sv
// Shared PWM types and constants used by the pulse-path blocks.
package pwm_pkg;

  typedef logic [7:0] pwm_width_t;

  localparam pwm_width_t PWM_NEUTRAL = 8'd127;
  localparam int unsigned PWM_UPDATE_DIV_20MS = 240000;

endpackage

// File: rtl/pwm_ramp_limiter_if.sv
// Command/width bundle between the bus peripheral and the ramp limiter.
interface pwm_ramp_limiter_if;
  import pwm_pkg::*;

  pwm_width_t target;
  logic       target_valid;
  pwm_width_t width;
  logic       update_tick;
  logic       at_target;
  logic       timed_out;

  modport master (
    output target,
    output target_valid,
    input  width,
    input  update_tick,
    input  at_target,
    input  timed_out
  );

  modport slave (
    input  target,
    input  target_valid,
    output width,
    output update_tick,
    output at_target,
    output timed_out
  );

endinterface

// File: rtl/pwm_tick_prescaler.sv
// Free-running divider: counts 0..DIV-1 and flags the last count, so the edge
// that wraps the counter is the tick edge.
module pwm_tick_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned DIV = PWM_UPDATE_DIV_20MS
) (
  input  logic clk_12MHz,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LastCnt);

endmodule

// File: rtl/pwm_ramp_limiter.sv
// Slew-rate limiter with optional command watchdog in front of the PWM generator.
// Define PWM_RAMP_WATCHDOG_EN to compile in the watchdog and neutral failsafe.
module pwm_ramp_limiter
  import pwm_pkg::*;
#(
  parameter int unsigned STEP            = 4,
  parameter int unsigned UPDATE_DIV      = PWM_UPDATE_DIV_20MS,
  parameter int unsigned TIMEOUT_UPDATES = 25,
  parameter pwm_width_t  NEUTRAL         = PWM_NEUTRAL
) (
  input  logic              clk_12MHz,
  input  logic              reset,
  pwm_ramp_limiter_if.slave bus
);

  if (STEP == 0 || STEP > 255 || TIMEOUT_UPDATES == 0 || TIMEOUT_UPDATES > 65535)
  begin : g_param_check
    $error("pwm_ramp_limiter: STEP or TIMEOUT_UPDATES out of range");
  end

  localparam logic [8:0] Step9 = 9'(STEP);

  logic       tick;
  pwm_width_t width_q, width_d;
  pwm_width_t target_q, target_d;
  logic       update_tick_q;
  logic       timed_out_q;
  logic [8:0] up_sum, down_floor;

  pwm_tick_prescaler #(
    .DIV(UPDATE_DIV)
  ) u_prescaler (
    .clk_12MHz(clk_12MHz),
    .reset    (reset),
    .tick     (tick)
  );

  // 9-bit compares keep the step from wrapping or overshooting the target.
  always_comb begin
    up_sum     = {1'b0, width_q} + Step9;
    down_floor = {1'b0, target_q} + Step9;
    width_d    = width_q;
    if (tick) begin
      if (width_q < target_q) begin
        width_d = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[7:0];
      end else if (width_q > target_q) begin
        width_d = ({1'b0, width_q} <= down_floor) ? target_q : width_q - Step9[7:0];
      end
    end
  end

`ifdef PWM_RAMP_WATCHDOG_EN
  localparam logic [15:0] Timeout = 16'(TIMEOUT_UPDATES);

  logic [15:0] wd_q, wd_d;
  logic        timed_out_d;

  // A command on the expiring tick wins over the failsafe.
  always_comb begin
    wd_d        = wd_q;
    target_d    = target_q;
    timed_out_d = timed_out_q;
    if (bus.target_valid) begin
      target_d    = bus.target;
      wd_d        = '0;
      timed_out_d = 1'b0;
    end else if (tick && (wd_q < Timeout)) begin
      wd_d = wd_q + 16'd1;
      if (wd_d == Timeout) begin
        timed_out_d = 1'b1;
        target_d    = NEUTRAL;
      end
    end
  end

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      wd_q        <= '0;
      timed_out_q <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      timed_out_q <= timed_out_d;
    end
  end
`else
  always_comb begin
    target_d = bus.target_valid ? bus.target : target_q;
  end

  assign timed_out_q = 1'b0;
`endif

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      width_q       <= NEUTRAL;
      target_q      <= NEUTRAL;
      update_tick_q <= 1'b0;
    end else begin
      width_q       <= width_d;
      target_q      <= target_d;
      update_tick_q <= tick;
    end
  end

  assign bus.width       = width_q;
  assign bus.update_tick = update_tick_q;
  assign bus.at_target   = (width_q == target_q);
  assign bus.timed_out   = timed_out_q;

endmodule

// File: tb/tb_pwm_ramp_limiter.sv
// Bench for pwm_ramp_limiter: directed tick table, async reset sequence and random
// commands against a cycle-level behavioural model. Honours PWM_RAMP_WATCHDOG_EN.
module tb_pwm_ramp_limiter;
  import pwm_pkg::*;

  localparam int Div  = 4;
  localparam int Step = 4;
  localparam int Tmo  = 3;
  localparam int Neut = 127;
`ifdef PWM_RAMP_WATCHDOG_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_ramp_limiter_if bus ();

  pwm_ramp_limiter #(
    .STEP           (Step),
    .UPDATE_DIV     (Div),
    .TIMEOUT_UPDATES(Tmo),
    .NEUTRAL        (8'(Neut))
  ) dut (
    .clk_12MHz(clk),
    .reset    (rst),
    .bus      (bus)
  );

  typedef struct {
    bit valid;
    bit on_tick;
    int tgt;
    int reps;
    int exp_w;
    bit exp_at;
    bit exp_to;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Reference state: cycles since reset, width, target, silent ticks, failsafe flag.
  int m_cnt, m_w, m_t, m_silent;
  bit m_to, m_tick;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_w = Neut; m_t = Neut; m_silent = 0; m_to = 0; m_tick = 0;
  endtask

  task automatic model_step(input bit v, input int tgt);
    bit tk;
    tk = (m_cnt % Div) == Div - 1;
    m_cnt++;
    if (tk) begin
      if (m_w < m_t) m_w = (m_w + Step > m_t) ? m_t : m_w + Step;
      else if (m_w > m_t) m_w = (m_w - Step < m_t) ? m_t : m_w - Step;
    end
    m_tick = tk;
    if (v) begin
      m_t = tgt; m_silent = 0; m_to = 0;
    end else if (WdEn && tk && m_silent < Tmo) begin
      m_silent++;
      if (m_silent == Tmo) begin
        m_to = 1; m_t = Neut;
      end
    end
  endtask

  task automatic clk_cycle(input bit v, input int tgt);
    bus.target_valid = v;
    bus.target = 8'(tgt);
    model_step(v, tgt);
    @(posedge clk);
    #1;
    bus.target_valid = 1'b0;
    n_cmp++;
    if (bus.width !== 8'(m_w) || bus.at_target !== (m_w == m_t) ||
        bus.timed_out !== m_to || bus.update_tick !== m_tick) begin
      n_fail++;
      $display("FAIL model_cycle %0d: width=%0d at=%0b to=%0b tick=%0b, expected %0d %0b %0b %0b",
               m_cnt, bus.width, bus.at_target, bus.timed_out, bus.update_tick,
               m_w, (m_w == m_t), m_to, m_tick);
    end
  endtask

  // Runs until the next update_tick; the strobe goes out right after the previous
  // tick, or on the tick edge itself when on_tick is set.
  task automatic run_to_tick(input bit v, input bit on_tick, input int tgt, output int cycles);
    bit drive;
    cycles = 0;
    for (int k = 0; k < 2 * Div; k++) begin
      drive = v && (on_tick ? ((m_cnt % Div) == Div - 1) : (k == 0));
      clk_cycle(drive, tgt);
      cycles++;
      if (bus.update_tick) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    int cyc;
    int dens;
    vec_t e;

    vecs.push_back('{0, 0, 0,   1,  127, 1, 0});
    vecs.push_back('{1, 0, 140, 1,  131, 0, 0});
    vecs.push_back('{1, 0, 140, 1,  135, 0, 0});
    vecs.push_back('{1, 0, 140, 1,  139, 0, 0});
    vecs.push_back('{1, 0, 140, 1,  140, 1, 0});
    vecs.push_back('{1, 0, 140, 1,  140, 1, 0});
    vecs.push_back('{1, 0, 2,   35, 2,   1, 0});
    vecs.push_back('{1, 0, 0,   1,  0,   1, 0});
    vecs.push_back('{1, 0, 253, 64, 253, 1, 0});
    vecs.push_back('{1, 0, 255, 1,  255, 1, 0});
    vecs.push_back('{1, 0, 200, 14, 200, 1, 0});
    vecs.push_back('{0, 0, 0,   1,  200, 1, 0});
`ifdef PWM_RAMP_WATCHDOG_EN
    vecs.push_back('{0, 0, 0,   1,  200, 0, 1});
    vecs.push_back('{0, 0, 0,   1,  196, 0, 1});
    vecs.push_back('{0, 0, 0,   18, 127, 1, 1});
`else
    vecs.push_back('{0, 0, 0,   1,  200, 1, 0});
    vecs.push_back('{0, 0, 0,   1,  200, 1, 0});
    vecs.push_back('{0, 0, 0,   18, 200, 1, 0});
`endif
    vecs.push_back('{1, 0, 127, 19, 127, 1, 0});
    vecs.push_back('{1, 0, 140, 1,  131, 0, 0});
    vecs.push_back('{0, 0, 0,   1,  135, 0, 0});
    vecs.push_back('{1, 1, 50,  1,  139, 0, 0});
    vecs.push_back('{0, 0, 0,   1,  135, 0, 0});
    vecs.push_back('{0, 0, 0,   1,  131, 0, 0});

    rst = 1'b1;
    bus.target_valid = 1'b0;
    bus.target = 8'd0;
    model_reset();
    #1;
    check("reset_width", int'(bus.width), Neut);
    check("reset_at_target", int'(bus.at_target), 1);
    check("reset_timed_out", int'(bus.timed_out), 0);
    check("reset_update_tick", int'(bus.update_tick), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    foreach (vecs[i]) begin
      e = vecs[i];
      for (int r = 0; r < e.reps; r++) begin
        run_to_tick(e.valid, e.on_tick, e.tgt, cyc);
        check($sformatf("tick_period[%0d]", i), cyc, Div);
      end
      check($sformatf("vec_width[%0d]", i), int'(bus.width), e.exp_w);
      check($sformatf("vec_at_target[%0d]", i), int'(bus.at_target), int'(e.exp_at));
      check($sformatf("vec_timed_out[%0d]", i), int'(bus.timed_out), int'(e.exp_to));
    end

    // Async reset mid-ramp, just after a tick so update_tick is high going in.
    run_to_tick(1'b1, 1'b0, 255, cyc);
    run_to_tick(1'b0, 1'b0, 0, cyc);
    run_to_tick(1'b0, 1'b0, 0, cyc);
    check("pre_reset_width", int'(bus.width), 143);
    check("pre_reset_timed_out", int'(bus.timed_out), int'(WdEn));
    check("pre_reset_update_tick", int'(bus.update_tick), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_width", int'(bus.width), Neut);
    check("async_reset_timed_out", int'(bus.timed_out), 0);
    check("async_reset_update_tick", int'(bus.update_tick), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_to_tick(1'b0, 1'b0, 0, cyc);
    check("first_tick_after_reset", cyc, Div);
    check("width_after_reset", int'(bus.width), Neut);

    for (int b = 0; b < 6; b++) begin
      dens = (b % 3 == 0) ? 2 : ((b % 3 == 1) ? 8 : 30);
      for (int n = 0; n < 150; n++) begin
        clk_cycle($urandom_range(0, dens) == 0, int'($urandom_range(0, 255)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_limiter.md
# pwm_ramp_limiter

Slew-rate limiter and command watchdog that sits directly upstream of the PWM pulse generator: it takes the 8-bit width written by the bus peripheral and produces the width actually driven into the generator. Each 20 ms update interval the output width moves toward the commanded target by at most `STEP` counts, so motor controllers never see step changes. If no new command arrives within a timeout, the target reverts to neutral and the output ramps back to it.

## Interface
Parameters:
- `STEP`, 4: maximum change in output width per update tick, 1..255.
- `UPDATE_DIV`, 240000: `clk_12MHz` cycles per update tick. The default gives 20 ms, one PWM frame.
- `TIMEOUT_UPDATES`, 25: ticks without a command before timeout (500 ms). Range 1..65535.
- `NEUTRAL`, 8'd127: reset and failsafe width.

Ports:
- `clk_12MHz`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high.
- `target`, in, 8: commanded width, 0 = 1 ms, 255 = 2 ms.
- `target_valid`, in, 1: one-cycle strobe; latches `target`.
- `width`, out, 8: ramped width to the PWM generator.
- `update_tick`, out, 1: one-cycle pulse coincident with each ramp update.
- `at_target`, out, 1: `width == target_reg`.
- `timed_out`, out, 1: watchdog has expired and the failsafe target is active.

## Operation
- Reset (asynchronous) values:
  - prescaler = 0, watchdog = 0.
  - `target_reg` = `NEUTRAL`, `width` = `NEUTRAL`.
  - `update_tick` = 0, `timed_out` = 0, `at_target` = 1.
- Prescaler counts 0..`UPDATE_DIV`-1 and wraps. A tick occurs on the edge where the prescaler equals `UPDATE_DIV`-1.
- `target_valid`:
  - `target_reg` <= `target`, watchdog <= 0, `timed_out` <= 0.
  - `target_valid` is honoured on every cycle, tick or not.
- Ramp, applied on a tick using the pre-edge `target_reg`:
  - If `width` < `target_reg`: `width` <= min(`width`+`STEP`, `target_reg`).
  - If `width` > `target_reg`: `width` <= max(`width`-`STEP`, `target_reg`).
  - Otherwise `width` is held.
  - Arithmetic is 9-bit, so there is no wrap and the result never overshoots the target or leaves 0..255.
- Watchdog, on a tick with no `target_valid`:
  - While below `TIMEOUT_UPDATES`, the watchdog increments.
  - On the tick where the incremented value reaches `TIMEOUT_UPDATES`: `timed_out` <= 1, `target_reg` <= `NEUTRAL`, and the watchdog saturates.
- Simultaneous `target_valid` and the expiring tick: `target_valid` wins. The watchdog is cleared, `timed_out` stays 0, and the new target is latched. That tick's ramp step uses the old `target_reg`.
- `timed_out` stays 1 until the next `target_valid` or reset.
- `at_target` is combinational from the `width` and `target_reg` registers.

## Timing
- `target_valid` to first `width` change: at the next tick edge, 1..`UPDATE_DIV` cycles later.
- `update_tick` is registered, high for exactly the one cycle following the tick edge, aligned with the new `width`.
- `width` changes only on tick edges or reset, so it is glitch-free for the downstream generator.
- Full-scale slew, 0 to 255: ceil(255/`STEP`) ticks.
- Reset asserted mid-ramp forces `width` to `NEUTRAL` immediately, without waiting for a clock edge. After deassertion the prescaler restarts from 0.

## Configuration
- `PWM_RAMP_WATCHDOG_EN` defined: the watchdog counter and the failsafe behaviour described above are compiled in.
- Not defined:
  - No watchdog register exists and `timed_out` is tied 0.
  - `target_reg` changes only on `target_valid` or reset.
  - `TIMEOUT_UPDATES` is ignored.

## Structure
- Shared package `pwm_pkg`:
  - typedef `pwm_width_t` (logic [7:0]).
  - constant `PWM_NEUTRAL` = 8'd127.
  - constant `PWM_UPDATE_DIV_20MS` = 240000.
- One sub-module, `pwm_tick_prescaler`: parameter `DIV`, ports `clk_12MHz`, `reset`, `tick`. It is reused for other frame-rate tasks.
- The ramp and watchdog logic live in the top module.

## Test plan
Bench parameters: `UPDATE_DIV`=4, `STEP`=4, `TIMEOUT_UPDATES`=3, `NEUTRAL`=127.
- Reset released, no commands: `width`=127 and `at_target`=1 from reset. `update_tick` pulses every 4 cycles.
- Up-ramp clamp: `target`=140 strobed. Successive ticks give `width` 131, 135, 139, 140, then hold; `at_target`=1 after the 140 tick.
- Extreme down-ramp: from `width`=2, `target`=0 gives `width`=0 in one tick with no underflow. From `width`=253, `target`=255 gives 255 with no overflow.
- Watchdog expiry: `target`=200 then silence. On the 3rd tick `timed_out`=1 and `target_reg`=127, and `width` ramps back down in steps of 4 to 127. A new `target_valid` clears `timed_out`.
- Simultaneous event: `target_valid` (`target`=50) on the same edge as the expiring tick. `timed_out` stays 0, `target_reg`=50, and that tick's step moves toward the old target.
- Async reset mid-ramp: `reset` pulsed between clock edges. `width`=127, `timed_out`=0 and `update_tick`=0 immediately, and the first tick arrives 4 cycles after release.
- With `PWM_RAMP_WATCHDOG_EN` undefined, repeat the watchdog scenario: `timed_out` stays 0 and `width` holds at 200.
